r6_column_feeder: RTL and testbench
===================================

Name: r6_column_feeder

Overview:
- Front end of the R6 (13x13) MRELBP central-intensity path.
- Takes a raster pixel stream and buffers 12 previous image rows in circular line memories.
- Each cycle it presents 13 vertically aligned pixels of the current column as S1..S13, which the R6 CI consumer accumulates.
- Generates the S-column valid strobe and the end-of-frame pulse for the downstream done_i/progress chain.

Parameters:
- COLS, 15, image width in pixels; must be >= 1; column counter width is 10 bits, so COLS <= 1023.
- ROWS, 15, image height in pixels; must be >= 13; row counter width is 10 bits, so ROWS <= 1023.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- done_i  input  1  pixel valid; data_i is consumed on every clk edge where done_i=1
- data_i  input  8  pixel, raster order: row 0 col 0..COLS-1, then row 1, ...
- S1..S13  output  8 each  column taps; S1 = oldest row (r-12), S13 = current row r, same column c
- done_o  output  1  S1..S13 valid strobe, one cycle per accepted pixel with r >= 12
- progress_done_o  output  1  one-cycle pulse when the last pixel of the frame has been output

Behaviour:
- Reset: all outputs are 0, and the col/row counters are 0.
  - Line-memory contents are not cleared; they are don't-care because output is gated by the row count.
- Storage: 12 line memories L0..L11, each COLS x 8 bits, addressed by col.
  - Lk holds row r-1-k.
- On an accepted pixel (done_i=1) at position (r,c), all of the following happen in the same edge:
  - S13 <= data_i.
  - S(12-k) <= Lk[c] for k = 0..11.
  - L0[c] <= data_i.
  - Lk[c] <= L(k-1)[c] for k = 1..11. Reads use the pre-update values.
  - done_o <= (r >= 12).
  - progress_done_o <= (r == ROWS-1 && c == COLS-1).
- Latency: 1 cycle from the accepted pixel to registered S1..S13/done_o.
- When done_i=0:
  - S1..S13 hold their values.
  - done_o and progress_done_o go to 0.
  - Counters hold.
  - Gaps of any length are legal.
- Counters:
  - c increments on each accepted pixel.
  - At c == COLS-1, c wraps to 0 and r increments.
  - At r == ROWS-1 and c == COLS-1, both wrap to 0 on the same edge; the next accepted pixel starts a new frame with no idle cycle required.
- State machine, advanced only on accepted pixels:
  - FILL (r < 12): done_o stays 0.
  - STREAM (12 <= r <= ROWS-1): done_o is 1 per accepted pixel.
  - Transition FILL->STREAM happens on the edge where r becomes 12.
  - Transition STREAM->FILL happens on frame wrap.
- Per frame, exactly (ROWS-12)*COLS done_o pulses and exactly one progress_done_o pulse occur.
  - The last done_o pulse is coincident with progress_done_o.
- Reset mid-frame:
  - Counters return to 0 and outputs clear on the next cycle.
  - The following pixel is treated as row 0 col 0.
  - Stale line-memory data never appears with done_o=1, because 12 full rows are refilled first.
- done_i asserted together with rst: reset wins and the pixel is dropped.
- Implementation freedom: line memories may be inferred RAM or register arrays. The 1-cycle latency and read-before-write semantics are mandatory.

Test Plan:
- Reset, then check outputs (COLS=ROWS=15):
  - After rst held 2 cycles -> all S=0, done_o=0, progress_done_o=0.
  - Then 180 valid pixels -> done_o stays 0 throughout.
- Continuous frame, data = (16*r + c) mod 256:
  - The 181st pixel (r=12, c=0) gives done_o=1 next cycle with S1=0x00, S7=0x60, S13=0xC0.
  - The pixel at r=14, c=14 gives S1=0x2E, S13=0xEE.
  - Total done_o pulses = 45.
- End of frame:
  - The 225th pixel gives done_o=1 and progress_done_o=1 on the same cycle, then both 0.
  - An immediate second frame with the same data produces an identical S sequence and 45 more pulses.
- Random gaps:
  - done_i toggled randomly (about 50% duty) on the same frame -> S values match the continuous run in order.
  - During gaps S holds, and done_o=1 only on cycles following an accepted pixel.
- Reset mid-frame:
  - rst asserted after pixel 200, then a full new frame with data = 0xFF - (16*r + c) -> first done_o after 181 new pixels.
  - S1=0xFF, S13=0x3F; no done_o before that point.
- Boundary, COLS=1, ROWS=13:
  - 13 pixels 1..13 -> exactly one done_o with S1=1 .. S13=13 and progress_done_o=1 on the same cycle.

Source files
------------

// File: rtl/r6_column_feeder_if.sv
// Pixel-in / 13-tap-column-out bus of the R6 central-intensity column feeder.
// The master drives pixels and consumes the column taps.
interface r6_column_feeder_if;
    logic       done_i;
    logic [7:0] data_i;
    logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13;
    logic       done_o;
    logic       progress_done_o;

    modport master (
        output done_i, data_i,
        input  S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13,
        input  done_o, progress_done_o
    );

    modport slave (
        input  done_i, data_i,
        output S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13,
        output done_o, progress_done_o
    );
endinterface

// File: rtl/r6_column_feeder.sv
// R6 (13x13) MRELBP column feeder: 12 circular line memories turn a raster
// pixel stream into 13 vertically aligned taps S1 (row r-12) .. S13 (row r).
module r6_column_feeder #(
    parameter int COLS = 15,
    parameter int ROWS = 15
) (
    input  logic          clk,
    input  logic          rst,
    r6_column_feeder_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int TAPS   = 13;
    localparam int LINES  = 12;
    localparam int AW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DEPTH  = 1 << AW;

    localparam logic [9:0] COL_LAST  = 10'(COLS - 1);
    localparam logic [9:0] ROW_LAST  = 10'(ROWS - 1);
    localparam logic [9:0] FILL_LAST = 10'd11;

    typedef enum logic {FILL, STREAM} state_e;

    state_e              state_q, state_d;
    logic [9:0]          col_q, col_d;
    logic [9:0]          row_q, row_d;
    logic                done_q, done_d;
    logic                prog_q, prog_d;
    logic [DATA_W-1:0]   tap_q  [TAPS];
    logic [DATA_W-1:0]   line_q [LINES][DEPTH];

    logic                accept;
    logic                col_wrap;
    logic                frame_end;
    logic [AW-1:0]       addr;

    assign accept    = bus.done_i;
    assign col_wrap  = (col_q == COL_LAST);
    assign frame_end = col_wrap && (row_q == ROW_LAST);
    assign addr      = col_q[AW-1:0];

    // STREAM is entered exactly when the row counter reaches 12, so the state
    // alone tells whether the current pixel completes a valid 13-row column.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        prog_d  = 1'b0;
        if (accept) begin
            done_d = (state_q == STREAM);
            prog_d = frame_end;
            if (col_wrap) begin
                col_d = '0;
                row_d = frame_end ? 10'd0 : row_q + 10'd1;
            end else begin
                col_d = col_q + 10'd1;
            end
            case (state_q)
                FILL:   if (col_wrap && (row_q == FILL_LAST)) state_d = STREAM;
                STREAM: if (frame_end) state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
            prog_q  <= 1'b0;
            for (int t = 0; t < TAPS; t++) tap_q[t] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
            prog_q  <= prog_d;
            if (accept) begin
                tap_q[TAPS-1] <= bus.data_i;
                for (int k = 0; k < LINES; k++) tap_q[LINES-1-k] <= line_q[k][addr];
            end
        end
    end

    // Line memories shift one row down per accepted pixel; reads above see the
    // pre-update contents. Not reset: stale rows are never emitted.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            line_q[0][addr] <= bus.data_i;
            for (int k = 1; k < LINES; k++) line_q[k][addr] <= line_q[k-1][addr];
        end
    end

    assign bus.S1  = tap_q[0];
    assign bus.S2  = tap_q[1];
    assign bus.S3  = tap_q[2];
    assign bus.S4  = tap_q[3];
    assign bus.S5  = tap_q[4];
    assign bus.S6  = tap_q[5];
    assign bus.S7  = tap_q[6];
    assign bus.S8  = tap_q[7];
    assign bus.S9  = tap_q[8];
    assign bus.S10 = tap_q[9];
    assign bus.S11 = tap_q[10];
    assign bus.S12 = tap_q[11];
    assign bus.S13 = tap_q[12];
    assign bus.done_o          = done_q;
    assign bus.progress_done_o = prog_q;
endmodule

// File: tb/tb_r6_column_feeder.sv
// Bench for r6_column_feeder: 2-D image model feeding a scoreboard, checkpoint
// table for hand-derived tap values, and a COLS=1/ROWS=13 boundary instance.
module tb_r6_column_feeder;
    localparam int C = 15;
    localparam int R = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    r6_column_feeder_if ifa ();
    r6_column_feeder_if ifb ();

    r6_column_feeder #(.COLS(C), .ROWS(R))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
    r6_column_feeder #(.COLS(1), .ROWS(13)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [7:0] sa [13];
    logic [7:0] sb [13];
    assign sa = '{ifa.S1, ifa.S2, ifa.S3, ifa.S4, ifa.S5, ifa.S6, ifa.S7,
                  ifa.S8, ifa.S9, ifa.S10, ifa.S11, ifa.S12, ifa.S13};
    assign sb = '{ifb.S1, ifb.S2, ifb.S3, ifb.S4, ifb.S5, ifb.S6, ifb.S7,
                  ifb.S8, ifb.S9, ifb.S10, ifb.S11, ifb.S12, ifb.S13};

    typedef struct packed {
        logic             prog;
        logic [12:0][7:0] s;
    } exp_t;

    typedef struct {
        int         kind;
        int         idx;
        bit         chk_s;
        logic [7:0] s1, s7, s13;
        bit         done, prog;
    } ckpt_t;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         mr, mc, pulses;
    logic [7:0] img [R][C];
    exp_t       q [$];
    ckpt_t      tbl [7];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock of DUT A with model update; outputs sampled 1 ns after the edge.
    task automatic step_a(input bit v, input logic [7:0] d, input bit r);
        exp_t       e;
        bit         exp_done;
        logic [7:0] prev [13];
        prev        = sa;
        ifa.done_i  = v;
        ifa.data_i  = d;
        rst         = r;
        exp_done    = 1'b0;
        e           = '0;
        if (r) begin
            mr = 0;
            mc = 0;
            q.delete();
        end else if (v) begin
            img[mr][mc] = d;
            if (mr >= 12) begin
                for (int j = 0; j < 13; j++) e.s[j] = img[mr-12+j][mc];
                e.prog = (mr == R-1) && (mc == C-1);
                q.push_back(e);
                exp_done = 1'b1;
            end
            if (mc == C-1) begin
                mc = 0;
                mr = (mr == R-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        if (ifa.done_o) pulses++;
        if (r) begin
            check("reset done_o", ifa.done_o, 0);
            check("reset progress_done_o", ifa.progress_done_o, 0);
            check("reset S1", sa[0], 0);
            check("reset S13", sa[12], 0);
        end else if (exp_done) begin
            check("done_o", ifa.done_o, 1);
            if (q.size() == 0) begin
                check("scoreboard entry present", 0, 1);
            end else begin
                e = q.pop_front();
                for (int j = 0; j < 13; j++) check($sformatf("S%0d", j+1), sa[j], e.s[j]);
                check("progress_done_o", ifa.progress_done_o, e.prog);
            end
        end else begin
            check("idle/fill done_o", ifa.done_o, 0);
            check("idle/fill progress_done_o", ifa.progress_done_o, 0);
            if (!v) for (int j = 0; j < 13; j++) check($sformatf("hold S%0d", j+1), sa[j], prev[j]);
        end
    endtask

    task automatic run_frame(input int inv, input bit gaps, input int npix);
        int         p;
        logic [7:0] val;
        p = 0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (p == npix) return;
                val = inv ? 8'(255 - (16*r + c)) : 8'(16*r + c);
                if (gaps) begin
                    int g = 0;
                    while (g < 6 && $urandom_range(1) == 0) begin
                        step_a(1'b0, 8'($urandom), 1'b0);
                        g++;
                    end
                end
                step_a(1'b1, val, 1'b0);
                p++;
                foreach (tbl[t]) begin
                    if (tbl[t].kind == inv && tbl[t].idx == p) begin
                        check($sformatf("ckpt %0d done_o", p), ifa.done_o, tbl[t].done);
                        check($sformatf("ckpt %0d progress", p), ifa.progress_done_o, tbl[t].prog);
                        if (tbl[t].chk_s) begin
                            check($sformatf("ckpt %0d S1", p), sa[0], tbl[t].s1);
                            check($sformatf("ckpt %0d S7", p), sa[6], tbl[t].s7);
                            check($sformatf("ckpt %0d S13", p), sa[12], tbl[t].s13);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 180, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{0, 181, 1'b1, 8'h00, 8'h60, 8'hC0, 1'b1, 1'b0};
        tbl[2] = '{0, 195, 1'b1, 8'h0E, 8'h6E, 8'hCE, 1'b1, 1'b0};
        tbl[3] = '{0, 225, 1'b1, 8'h2E, 8'h8E, 8'hEE, 1'b1, 1'b1};
        tbl[4] = '{1, 180, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{1, 181, 1'b1, 8'hFF, 8'h9F, 8'h3F, 1'b1, 1'b0};
        tbl[6] = '{1, 225, 1'b1, 8'hD1, 8'h71, 8'h11, 1'b1, 1'b1};

        mr = 0; mc = 0; pulses = 0;
        ifa.done_i = 1'b0; ifa.data_i = '0;
        ifb.done_i = 1'b0; ifb.data_i = '0;

        step_a(1'b0, 8'h00, 1'b1);
        step_a(1'b0, 8'h00, 1'b1);

        pulses = 0;
        run_frame(0, 1'b0, 225);
        check("frame 1 done_o pulses", pulses, 45);

        pulses = 0;
        run_frame(0, 1'b0, 225);
        step_a(1'b0, 8'h00, 1'b0);
        check("frame 2 done_o pulses", pulses, 45);

        pulses = 0;
        run_frame(0, 1'b1, 225);
        step_a(1'b0, 8'h00, 1'b0);
        check("gapped frame done_o pulses", pulses, 45);

        run_frame(0, 1'b0, 200);
        step_a(1'b1, 8'h55, 1'b1);
        pulses = 0;
        run_frame(1, 1'b0, 225);
        step_a(1'b0, 8'h00, 1'b0);
        check("post-reset frame done_o pulses", pulses, 45);

        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i <= 13; i++) begin
                ifb.done_i = 1'b1;
                ifb.data_i = 8'(i + 20*f);
                @(posedge clk);
                #1;
                if (i < 13) begin
                    check("B fill done_o", ifb.done_o, 0);
                end else begin
                    check("B done_o", ifb.done_o, 1);
                    check("B progress_done_o", ifb.progress_done_o, 1);
                    for (int j = 0; j < 13; j++) check($sformatf("B S%0d", j+1), sb[j], j + 1 + 20*f);
                end
            end
            ifb.done_i = 1'b0;
            @(posedge clk);
            #1;
            check("B idle done_o", ifb.done_o, 0);
            check("B idle progress_done_o", ifb.progress_done_o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
